// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_pkg
// Brief    : Shared types and default constants for the SRAM port controller
// Revision : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ACC  = 3'd1,
        ST_WR_ACC  = 3'd2,
        ST_RD_DONE = 3'd3,
        ST_WR_DONE = 3'd4
    } state_t;

    localparam int c_rd_lat_def  = 2;
    localparam int c_wr_lat_def  = 2;
    localparam int c_rd_base_def = 0;
    localparam int c_wr_base_def = 65536;

endpackage
`default_nettype wire

// File: rtl/sram_addr_ptr.sv
`default_nettype none
// ============================================================================
// Module   : sram_addr_ptr
// Brief    : Wrapping next/cur pixel pointer with deferred increment and
//            one-cycle ready pulse
// Revision : 1.0 - initial release
// ============================================================================
module sram_addr_ptr #(
    parameter int NUM_PIXELS = 65536,
    parameter int PTR_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    input  logic             i_busy,
    input  logic             i_acc_done,
    output logic [PTR_W-1:0] o_cur,
    output logic             o_ready
);

    localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_PIXELS - 1);

    logic [PTR_W-1:0] r_next;
    logic [PTR_W-1:0] r_cur;
    logic             r_defer;
    logic             r_ready;
    logic             w_apply;

    // An increment landing in the completion cycle itself is applied at once.
    assign w_apply = (i_inc & ~i_busy) | (i_acc_done & (r_defer | i_inc));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_next  <= '0;
            r_cur   <= '0;
            r_defer <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            if (w_apply) begin
                r_cur  <= r_next;
                r_next <= (r_next == c_last) ? '0 : r_next + PTR_W'(1);
            end
            r_defer <= (r_defer | i_inc) & ~w_apply;
            r_ready <= w_apply;
        end
    end

    assign o_cur   = r_cur;
    assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_ctrl
// Brief    : Arbitrated read/write controller for a single shared SRAM port
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 32,
    parameter int NUM_PIXELS = 65536,
    parameter int RD_BASE    = c_rd_base_def,
    parameter int WR_BASE    = c_wr_base_def,
    parameter int RD_LAT     = c_rd_lat_def,
    parameter int WR_LAT     = c_wr_lat_def
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc_raddr,
    input  logic              i_inc_waddr,
    input  logic              i_re,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clear_done,
    output logic              o_raddr_ready,
    output logic              o_waddr_ready,
    output logic              o_read_complete,
    output logic              o_write_complete,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_ren,
    output logic              o_sram_wen,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata
);

    localparam int c_ptr_w   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int c_cnt_w   = $clog2(NUM_PIXELS + 1);
    localparam int c_lat_max = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int c_lat_w   = $clog2(c_lat_max + 1);

    localparam logic [ADDR_W-1:0]  c_rd_base = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0]  c_wr_base = ADDR_W'(WR_BASE);
    localparam logic [c_cnt_w-1:0] c_num     = c_cnt_w'(NUM_PIXELS);
    localparam logic [c_cnt_w-1:0] c_num_m1  = c_cnt_w'(NUM_PIXELS - 1);
    localparam logic [c_lat_w-1:0] c_rd_end  = c_lat_w'(RD_LAT - 1);
    localparam logic [c_lat_w-1:0] c_wr_end  = c_lat_w'(WR_LAT - 1);

    state_t              r_state;
    logic                r_rd_pend;
    logic                r_wr_pend;
    logic                r_last_rd;
    logic [c_lat_w-1:0]  r_lat_cnt;
    logic [DATA_W-1:0]   r_wdata_hold;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ren;
    logic                r_wen;
    logic                r_rd_cmp;
    logic                r_wr_cmp;
    logic                r_done;
    logic                r_err;
    logic [c_cnt_w-1:0]  r_wcnt;

    logic [c_ptr_w-1:0]  w_rcur;
    logic [c_ptr_w-1:0]  w_wcur;
    logic                w_rd_done_st;
    logic                w_wr_done_st;
    logic                w_re_acc;
    logic                w_we_acc;
    logic                w_req_err;
    logic                w_rd_want;
    logic                w_wr_want;
    logic                w_pick_rd;

    assign w_rd_done_st = (r_state == ST_RD_DONE);
    assign w_wr_done_st = (r_state == ST_WR_DONE);

    // A DONE cycle releases its kind, so a new request there is accepted.
    assign w_re_acc  = i_re & ~(r_rd_pend & ~w_rd_done_st);
    assign w_we_acc  = i_we & ~r_done & ~(r_wr_pend & ~w_wr_done_st);
    assign w_req_err = (i_re & ~w_re_acc) | (i_we & ~w_we_acc);

    assign w_rd_want = r_rd_pend | w_re_acc;
    assign w_wr_want = r_wr_pend | w_we_acc;
    assign w_pick_rd = w_rd_want & (~w_wr_want | ~r_last_rd);

    sram_addr_ptr #(
        .NUM_PIXELS (NUM_PIXELS),
        .PTR_W      (c_ptr_w)
    ) u_rd_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear_done),
        .i_inc      (i_inc_raddr),
        .i_busy     (r_rd_pend),
        .i_acc_done (w_rd_done_st),
        .o_cur      (w_rcur),
        .o_ready    (o_raddr_ready)
    );

    sram_addr_ptr #(
        .NUM_PIXELS (NUM_PIXELS),
        .PTR_W      (c_ptr_w)
    ) u_wr_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (i_clear_done),
        .i_inc      (i_inc_waddr),
        .i_busy     (r_wr_pend),
        .i_acc_done (w_wr_done_st),
        .o_cur      (w_wcur),
        .o_ready    (o_waddr_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rd_pend    <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_last_rd    <= 1'b0;
            r_lat_cnt    <= '0;
            r_wdata_hold <= '0;
            r_rdata      <= '0;
            r_ren        <= 1'b0;
            r_wen        <= 1'b0;
            r_rd_cmp     <= 1'b0;
            r_wr_cmp     <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_wcnt       <= '0;
        end else begin
            r_rd_cmp  <= 1'b0;
            r_wr_cmp  <= 1'b0;
            r_rd_pend <= w_re_acc | (r_rd_pend & ~w_rd_done_st);
            r_wr_pend <= w_we_acc | (r_wr_pend & ~w_wr_done_st);
            r_err     <= w_req_err | (r_err & ~i_clear_done);
            if (w_we_acc) begin
                r_wdata_hold <= i_wdata;
            end

            if (i_clear_done) begin
                r_wcnt <= '0;
                r_done <= 1'b0;
            end else if (w_wr_done_st && (r_wcnt != c_num)) begin
                r_wcnt <= r_wcnt + c_cnt_w'(1);
                if (r_wcnt == c_num_m1) begin
                    r_done <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_lat_cnt <= '0;
                    if (w_pick_rd) begin
                        r_state <= ST_RD_ACC;
                        r_ren   <= 1'b1;
                    end else if (w_wr_want) begin
                        r_state <= ST_WR_ACC;
                        r_wen   <= 1'b1;
                    end
                end
                ST_RD_ACC: begin
                    if (r_lat_cnt == c_rd_end) begin
                        r_ren    <= 1'b0;
                        r_rdata  <= i_sram_rdata;
                        r_rd_cmp <= 1'b1;
                        r_state  <= ST_RD_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
                    end
                end
                ST_WR_ACC: begin
                    if (r_lat_cnt == c_wr_end) begin
                        r_wen    <= 1'b0;
                        r_wr_cmp <= 1'b1;
                        r_state  <= ST_WR_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_lat_w'(1);
                    end
                end
                ST_RD_DONE: begin
                    r_last_rd <= 1'b1;
                    r_state   <= ST_IDLE;
                end
                ST_WR_DONE: begin
                    r_last_rd <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ren   <= 1'b0;
                    r_wen   <= 1'b0;
                end
            endcase
        end
    end

    assign o_sram_ren       = r_ren;
    assign o_sram_wen       = r_wen;
    assign o_sram_addr      = r_ren ? (c_rd_base + ADDR_W'(w_rcur)) :
                              r_wen ? (c_wr_base + ADDR_W'(w_wcur)) : '0;
    assign o_sram_wdata     = r_wen ? r_wdata_hold : '0;
    assign o_read_complete  = r_rd_cmp;
    assign o_write_complete = r_wr_cmp;
    assign o_rdata          = r_rdata;
    assign o_done           = r_done;
    assign o_err            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_ctrl
// Brief    : Directed self-checking bench for sram_port_ctrl (4-pixel frame)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_port_ctrl;

    localparam int ADDR_W     = 18;
    localparam int DATA_W     = 32;
    localparam int NUM_PIXELS = 4;
    localparam int RD_BASE    = 0;
    localparam int WR_BASE    = 65536;
    localparam int RD_LAT     = 2;
    localparam int WR_LAT     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_inc_raddr, i_inc_waddr, i_re, i_we, i_clear_done;
    logic [DATA_W-1:0] i_wdata;
    logic              o_raddr_ready, o_waddr_ready, o_read_complete, o_write_complete;
    logic [DATA_W-1:0] o_rdata;
    logic              o_done, o_err;
    logic [ADDR_W-1:0] o_sram_addr;
    logic              o_sram_ren, o_sram_wen;
    logic [DATA_W-1:0] o_sram_wdata;
    logic [DATA_W-1:0] i_sram_rdata;
    logic [89:0]       w_all_out;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // SRAM contents: data word is a fixed pattern XOR the address
    assign i_sram_rdata = 32'hA5A5_0000 ^ {14'd0, o_sram_addr};

    assign w_all_out = {o_raddr_ready, o_waddr_ready, o_read_complete, o_write_complete,
                        o_rdata, o_done, o_err, o_sram_addr, o_sram_ren, o_sram_wen,
                        o_sram_wdata};

    sram_port_ctrl #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_PIXELS (NUM_PIXELS),
        .RD_BASE    (RD_BASE),
        .WR_BASE    (WR_BASE),
        .RD_LAT     (RD_LAT),
        .WR_LAT     (WR_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_inc_raddr      (i_inc_raddr),
        .i_inc_waddr      (i_inc_waddr),
        .i_re             (i_re),
        .i_we             (i_we),
        .i_wdata          (i_wdata),
        .i_clear_done     (i_clear_done),
        .o_raddr_ready    (o_raddr_ready),
        .o_waddr_ready    (o_waddr_ready),
        .o_read_complete  (o_read_complete),
        .o_write_complete (o_write_complete),
        .o_rdata          (o_rdata),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_sram_addr      (o_sram_addr),
        .o_sram_ren       (o_sram_ren),
        .o_sram_wen       (o_sram_wen),
        .o_sram_wdata     (o_sram_wdata),
        .i_sram_rdata     (i_sram_rdata)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge and drop all pulse inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        i_re         = 1'b0;
        i_we         = 1'b0;
        i_inc_raddr  = 1'b0;
        i_inc_waddr  = 1'b0;
        i_clear_done = 1'b0;
    endtask

    task automatic do_inc_r();
        i_inc_raddr = 1'b1;
        cyc();
        chk("inc_r_ready", o_raddr_ready, 1);
    endtask

    task automatic do_inc_w();
        i_inc_waddr = 1'b1;
        cyc();
        chk("inc_w_ready", o_waddr_ready, 1);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        i_re = 1'b1;
        cyc();
        chk("rd_ren_first", o_sram_ren, 1);
        chk("rd_addr", o_sram_addr, a);
        cyc();
        chk("rd_ren_second", o_sram_ren, 1);
        cyc();
        chk("rd_complete", o_read_complete, 1);
        chk("rd_data", o_rdata, 32'hA5A5_0000 ^ {14'd0, a});
        chk("rd_ren_off", o_sram_ren, 0);
        cyc();
    endtask

    task automatic do_write(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                            input logic exp_done);
        i_we    = 1'b1;
        i_wdata = d;
        cyc();
        chk("wr_wen_first", o_sram_wen, 1);
        chk("wr_ren_low", o_sram_ren, 0);
        chk("wr_addr", o_sram_addr, a);
        chk("wr_wdata", o_sram_wdata, d);
        cyc();
        chk("wr_wen_second", o_sram_wen, 1);
        cyc();
        chk("wr_complete", o_write_complete, 1);
        chk("wr_wen_off", o_sram_wen, 0);
        cyc();
        chk("wr_done_flag", o_done, exp_done);
    endtask

    initial begin
        rst = 1'b1; i_re = 0; i_we = 0; i_inc_raddr = 0; i_inc_waddr = 0;
        i_clear_done = 0; i_wdata = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("reset_outputs", w_all_out, 0);

        // 1: increment then read at address 0
        i_inc_raddr = 1'b1;
        cyc();
        chk("t1_raddr_ready", o_raddr_ready, 1);
        i_re = 1'b1;
        cyc();
        chk("t1_ready_pulse", o_raddr_ready, 0);
        chk("t1_ren_a", o_sram_ren, 1);
        chk("t1_addr", o_sram_addr, 0);
        cyc();
        chk("t1_ren_b", o_sram_ren, 1);
        chk("t1_no_cmp_early", o_read_complete, 0);
        cyc();
        chk("t1_cmp", o_read_complete, 1);
        chk("t1_rdata", o_rdata, 32'hA5A5_0000);
        chk("t1_ren_off", o_sram_ren, 0);
        cyc();
        chk("t1_cmp_pulse", o_read_complete, 0);
        chk("t1_rdata_hold", o_rdata, 32'hA5A5_0000);

        // 2: collisions, fresh history
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        do_inc_r();
        i_re = 1'b1; i_we = 1'b1; i_wdata = 32'hDEAD_0001;
        cyc();
        chk("t2_rd_first", o_sram_ren, 1);
        chk("t2_wen_low", o_sram_wen, 0);
        cyc();
        cyc();
        chk("t2_rd_cmp", o_read_complete, 1);
        chk("t2_wen_low_done", o_sram_wen, 0);
        cyc();
        chk("t2_gap", o_sram_wen, 0);
        cyc();
        chk("t2_wen", o_sram_wen, 1);
        chk("t2_waddr", o_sram_addr, 18'h10000);
        chk("t2_wdata", o_sram_wdata, 32'hDEAD_0001);
        cyc();
        cyc();
        chk("t2_wr_cmp", o_write_complete, 1);
        cyc();
        do_read(18'h0);
        i_re = 1'b1; i_we = 1'b1; i_wdata = 32'hDEAD_0002;
        cyc();
        chk("t2b_wr_first", o_sram_wen, 1);
        chk("t2b_ren_low", o_sram_ren, 0);
        chk("t2b_wdata", o_sram_wdata, 32'hDEAD_0002);
        cyc();
        cyc();
        chk("t2b_wr_cmp", o_write_complete, 1);
        cyc();
        chk("t2b_gap", o_sram_ren, 0);
        cyc();
        chk("t2b_rd_after", o_sram_ren, 1);
        cyc();
        cyc();
        chk("t2b_rd_cmp", o_read_complete, 1);
        cyc();

        // 3: increment during an active read is deferred
        i_re = 1'b1;
        cyc();
        chk("t3_ren", o_sram_ren, 1);
        chk("t3_addr0", o_sram_addr, 0);
        i_inc_raddr = 1'b1;
        cyc();
        chk("t3_addr_hold", o_sram_addr, 0);
        chk("t3_no_ready", o_raddr_ready, 0);
        cyc();
        chk("t3_cmp", o_read_complete, 1);
        chk("t3_no_ready_cmp", o_raddr_ready, 0);
        cyc();
        chk("t3_ready_after", o_raddr_ready, 1);
        do_read(18'h1);

        // 4: read pointer wraps at NUM_PIXELS
        do_inc_r();
        do_read(18'h2);
        do_inc_r();
        do_read(18'h3);
        do_inc_r();
        do_read(18'h0);

        // 5: frame done after four writes
        i_clear_done = 1'b1;
        cyc();
        chk("t5_done_clr0", o_done, 0);
        for (int k = 0; k < NUM_PIXELS; k++) begin
            do_inc_w();
            do_write(32'hC0DE_0000 + k, 18'h10000 + 18'(k), k == NUM_PIXELS - 1);
        end
        i_we = 1'b1; i_wdata = 32'h0000_0BAD;
        cyc();
        chk("t5_err", o_err, 1);
        chk("t5_no_wen", o_sram_wen, 0);
        cyc();
        chk("t5_no_wen2", o_sram_wen, 0);
        cyc();
        chk("t5_no_cmp", o_write_complete, 0);
        i_clear_done = 1'b1;
        cyc();
        chk("t5_done_clr", o_done, 0);
        chk("t5_err_clr", o_err, 0);
        do_inc_w();
        do_write(32'h1234_5678, 18'h10000, 1'b0);

        // 6: duplicate read request, then reset mid-write
        i_re = 1'b1;
        cyc();
        chk("t6_ren", o_sram_ren, 1);
        chk("t6_err_before", o_err, 0);
        i_re = 1'b1;
        cyc();
        chk("t6_dup_err", o_err, 1);
        chk("t6_ren_cont", o_sram_ren, 1);
        cyc();
        chk("t6_rd_cmp", o_read_complete, 1);
        cyc();
        i_we = 1'b1; i_wdata = 32'hFACE_0001;
        cyc();
        chk("t6_wen", o_sram_wen, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_rst_outputs", w_all_out, 0);
        cyc();
        chk("t6_no_cmp_a", o_write_complete, 0);
        chk("t6_no_wen_a", o_sram_wen, 0);
        cyc();
        chk("t6_no_cmp_b", o_write_complete, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Controller for the single shared SRAM port used by the edge-detection pipeline. It owns the read and write address pointers and serves the main control unit's increment, read-enable and write-enable pulses. When a read and a write are pending together, it arbitrates between them. It returns the ready and complete pulses the control FSM waits on, and it raises a frame-done flag after the last output pixel is written.

## Interface
Parameters:
- ADDR_W, 18: SRAM address width.
- DATA_W, 32: SRAM data width.
- NUM_PIXELS, 65536: pixels per frame, ≥2.
- RD_BASE, 0: input image base address.
- WR_BASE, 65536: output image base address.
- RD_LAT, 2: cycles the read strobe is held (≥1).
- WR_LAT, 2: cycles the write strobe is held (≥1).

Ports:
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- i_inc_raddr  in  1: advance read pointer (1-cycle pulse).
- i_inc_waddr  in  1: advance write pointer (1-cycle pulse).
- i_re  in  1: request read at current read address (pulse).
- i_we  in  1: request write at current write address (pulse).
- i_wdata  in  DATA_W: write data, sampled in the cycle i_we is high.
- i_clear_done  in  1: clear o_done and restart both pointers.
- o_raddr_ready  out  1: read address updated (pulse).
- o_waddr_ready  out  1: write address updated (pulse).
- o_read_complete  out  1: o_rdata valid (pulse).
- o_write_complete  out  1: write finished (pulse).
- o_rdata  out  DATA_W: last read data, held until next read completes.
- o_done  out  1: NUM_PIXELS writes completed, sticky.
- o_err  out  1: sticky protocol error.
- o_sram_addr  out  ADDR_W: SRAM address.
- o_sram_ren  out  1: SRAM read strobe.
- o_sram_wen  out  1: SRAM write strobe.
- o_sram_wdata  out  DATA_W: SRAM write data.
- i_sram_rdata  in  DATA_W: SRAM read data.

## Operation
**Pointers**
- Read pointer: rnext (0..NUM_PIXELS-1) and rcur. Write pointer: wnext and wcur, same structure.
- An increment does rcur<=rnext and rnext<=(rnext==NUM_PIXELS-1)?0:rnext+1. Write pointer identical.
- Effective read address is RD_BASE+rcur; effective write address is WR_BASE+wcur.

**Deferred increments**
- An increment that arrives while an access of the same kind is pending or active is latched.
- It is applied in the cycle after that access completes.

**Requests**
- i_re or i_we sets a pending flag. i_we also captures i_wdata into a holding register.
- A request while the same kind is already pending or active is ignored and sets o_err.

**State machine**
- States: IDLE, RD_ACC, WR_ACC, RD_DONE, WR_DONE.
- IDLE with only read pending → RD_ACC. IDLE with only write pending → WR_ACC.
- IDLE with both pending → the kind not last granted; read after reset.
- RD_ACC: o_sram_ren=1, o_sram_addr=RD_BASE+rcur for RD_LAT cycles (latency counter). i_sram_rdata is captured into o_rdata on the last cycle → RD_DONE.
- WR_ACC: o_sram_wen=1, addr=WR_BASE+wcur, wdata from holding register, for WR_LAT cycles → WR_DONE.
- RD_DONE / WR_DONE: pulse the matching complete output, clear the pending flag, update last-granted → IDLE.
- ren and wen are never high in the same cycle.

**Frame done**
- A write-complete counter counts 0..NUM_PIXELS. When it reaches NUM_PIXELS, o_done=1.
- While o_done is high, further i_we sets o_err and is not performed.
- i_clear_done clears o_done, o_err, all pointers and the counter. It does not abort an active access.

## Timing
**Reset**
- On reset, all outputs are 0, including o_rdata and o_sram_addr.
- FSM goes to IDLE; pointers, counters, pending flags and last-granted are cleared.
- Reset mid-access drops the strobes in the next cycle; no complete pulse is issued.

**Address ready**
- o_raddr_ready and o_waddr_ready pulse the cycle after the pointer update: one cycle after the increment, or one cycle after completion if the increment was deferred.

**Read latency**
- i_re at cycle t with the port idle: ren high t+1..t+RD_LAT.
- o_read_complete at t+RD_LAT+1.

**Write latency**
- Same shape as the read, using WR_LAT and o_write_complete.

**Back-to-back**
- A request arriving in a DONE cycle is granted from IDLE in the following cycle, so there is a minimum 1-cycle gap between accesses.

**Simultaneous events**
- Simultaneous i_re and i_we in IDLE with no history: read first.
- The write then starts the cycle after RD_DONE.

## Structure
- Shared package sram_ctrl_pkg holds the state enum typedef, the default latency constants and the base address constants.
- One sub-module, sram_addr_ptr, is instantiated twice (read and write). It contains next/cur registers, wrap logic, the deferred-increment latch and the ready pulse.

## Test plan
1. Reset, then inc_raddr and re with RD_LAT=2 → raddr_ready one cycle later; ren for 2 cycles at addr 0; read_complete with o_rdata = SRAM value.
2. Simultaneous re and we from IDLE → read served first; write starts the cycle after RD_DONE. A second collision serves the write first.
3. inc_raddr during an active read → addr unchanged during the access; raddr_ready in the cycle after read_complete; next read at addr 1.
4. Drive NUM_PIXELS=4 through the read pointer → increments give 0,1,2,3 then wrap to 0.
5. NUM_PIXELS=4 writes → o_done after the 4th write_complete; a 5th we sets o_err with no wen; i_clear_done clears both and the next write goes to WR_BASE.
6. Duplicate re while a read is pending sets o_err; assert rst mid-WR_ACC → wen low the next cycle, no write_complete, all outputs 0.
